// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: load funct3 codes,
// FSM state encoding and the captured instruction bundle.
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_HALTED    = 2'd2
  } state_e;

  // Everything taken from MEM at accept time and replayed to WB.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu_out;
    logic [31:0] csr_out;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic        write_gpr;
    logic        write_csr;
    logic        mem_to_reg;
    logic        system_halt;
    logic        op_valid;
    logic        alu_valid;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: selects the byte/half lane from a word-aligned
// memory response and sign- or zero-extends it to 32 bits.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr_low,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and extension; unknown funct3 codes fall back to a full word.
  always_comb begin
    byte_lane = raw_word[7:0];
    case (addr_low)
      2'd0:    byte_lane = raw_word[7:0];
      2'd1:    byte_lane = raw_word[15:8];
      2'd2:    byte_lane = raw_word[23:16];
      default: byte_lane = raw_word[31:24];
    endcase
    half_lane = addr_low[1] ? raw_word[31:16] : raw_word[15:0];

    case (load_type)
      F3_LB:   result = {{24{byte_lane[7]}}, byte_lane};
      F3_LBU:  result = {24'd0, byte_lane};
      F3_LH:   result = {{16{half_lane[15]}}, half_lane};
      F3_LHU:  result = {16'd0, half_lane};
      default: result = raw_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM -> WB pipeline stage. Accepts one instruction per valid/ready
// handshake, waits for load data when needed and emits a registered
// one-cycle commit bundle. After a halting instruction is taken the stage
// stops accepting until reset.
// Optional feature: define MEMWB_PERF_CNT_EN to add perf_retired and
// perf_load_wait counters.
//
// Handshake: a transfer from MEM happens on a rising edge where
// MEM_valid & MEM_ready are both 1; MEM_ready depends only on state and rst,
// never on MEM_valid. dmem_rvalid is a single-cycle response strobe that is
// only looked at while a load is outstanding.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  output logic        MEM_ready,
  input  logic [31:0] MEM_pc,
  input  logic [31:0] MEM_inst,
  input  logic [31:0] MEM_ALUout,
  input  logic [31:0] MEM_CSR_out,
  input  logic [4:0]  MEM_rd,
  input  logic [1:0]  MEM_csr_rd,
  input  logic        MEM_write_gpr,
  input  logic        MEM_write_csr,
  input  logic        MEM_mem_to_reg,
  input  logic        MEM_system_halt,
  input  logic        MEM_op_valid,
  input  logic        MEM_ALU_valid,
  input  logic [2:0]  MEM_load_type,
  input  logic [1:0]  MEM_addr_low,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        WB_i_commit,
  output logic [31:0] WB_i_pc,
  output logic [31:0] WB_i_inst,
  output logic [31:0] WB_i_ALU_ALUout,
  output logic [31:0] WB_i_ALU_CSR_out,
  output logic [31:0] WB_i_rdata,
  output logic [4:0]  WB_i_rd,
  output logic [1:0]  WB_i_csr_rd,
  output logic        WB_i_write_gpr,
  output logic        WB_i_write_csr,
  output logic        WB_i_mem_to_reg,
  output logic        WB_i_system_halt,
  output logic        WB_i_op_valid,
  output logic        WB_i_ALU_valid
`ifdef MEMWB_PERF_CNT_EN
  ,
  output logic [63:0] perf_retired,
  output logic [31:0] perf_load_wait
`endif
);

  state_e      state_q, state_d;
  wb_bundle_t  bundle_q, bundle_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  laddr_q, laddr_d;
  logic        commit_q, commit_d;
  logic [31:0] aligned_data;
  logic        accept;
  wb_bundle_t  mem_bundle;

  load_align u_load_align (
    .raw_word  (dmem_rdata),
    .load_type (ltype_q),
    .addr_low  (laddr_q),
    .result    (aligned_data)
  );

  assign MEM_ready = (state_q == ST_IDLE) & ~rst;
  assign accept    = MEM_valid & MEM_ready;

  // Pack the incoming MEM fields so they can be captured as one unit.
  always_comb begin
    mem_bundle.pc          = MEM_pc;
    mem_bundle.inst        = MEM_inst;
    mem_bundle.alu_out     = MEM_ALUout;
    mem_bundle.csr_out     = MEM_CSR_out;
    mem_bundle.rd          = MEM_rd;
    mem_bundle.csr_rd      = MEM_csr_rd;
    mem_bundle.write_gpr   = MEM_write_gpr;
    mem_bundle.write_csr   = MEM_write_csr;
    mem_bundle.mem_to_reg  = MEM_mem_to_reg;
    mem_bundle.system_halt = MEM_system_halt;
    mem_bundle.op_valid    = MEM_op_valid;
    mem_bundle.alu_valid   = MEM_ALU_valid;
  end

  // Next-state and capture logic. A halting instruction moves to HALTED on
  // the same edge that schedules its commit, so nothing is accepted behind it.
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    rdata_d  = rdata_q;
    ltype_d  = ltype_q;
    laddr_d  = laddr_q;
    commit_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bundle_d = mem_bundle;
          ltype_d  = MEM_load_type;
          laddr_d  = MEM_addr_low;
          if (MEM_mem_to_reg) begin
            state_d = ST_WAIT_LOAD;
          end else begin
            commit_d = 1'b1;
            if (MEM_system_halt) state_d = ST_HALTED;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          rdata_d  = aligned_data;
          commit_d = 1'b1;
          state_d  = bundle_q.system_halt ? ST_HALTED : ST_IDLE;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and bundle registers; reset clears every output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bundle_q <= '0;
      rdata_q  <= '0;
      ltype_q  <= '0;
      laddr_q  <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      rdata_q  <= rdata_d;
      ltype_q  <= ltype_d;
      laddr_q  <= laddr_d;
      commit_q <= commit_d;
    end
  end

  assign WB_i_commit      = commit_q;
  assign WB_i_pc          = bundle_q.pc;
  assign WB_i_inst        = bundle_q.inst;
  assign WB_i_ALU_ALUout  = bundle_q.alu_out;
  assign WB_i_ALU_CSR_out = bundle_q.csr_out;
  assign WB_i_rdata       = rdata_q;
  assign WB_i_rd          = bundle_q.rd;
  assign WB_i_csr_rd      = bundle_q.csr_rd;
  assign WB_i_write_gpr   = bundle_q.write_gpr & commit_q & (bundle_q.rd != 5'd0);
  assign WB_i_write_csr   = bundle_q.write_csr & commit_q;
  assign WB_i_mem_to_reg  = bundle_q.mem_to_reg;
  assign WB_i_system_halt = bundle_q.system_halt;
  assign WB_i_op_valid    = bundle_q.op_valid;
  assign WB_i_ALU_valid   = bundle_q.alu_valid;

`ifdef MEMWB_PERF_CNT_EN
  logic [63:0] retired_q, retired_d;
  logic [31:0] load_wait_q, load_wait_d;

  // Counter increments; both wrap naturally on overflow.
  always_comb begin
    retired_d   = retired_q;
    load_wait_d = load_wait_q;
    if (commit_d) retired_d = retired_q + 64'd1;
    if ((state_q == ST_WAIT_LOAD) && !dmem_rvalid) load_wait_d = load_wait_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q   <= '0;
      load_wait_q <= '0;
    end else begin
      retired_q   <= retired_d;
      load_wait_q <= load_wait_d;
    end
  end

  assign perf_retired   = retired_q;
  assign perf_load_wait = load_wait_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model.
module tb_mem_wb_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        MEM_valid = 0, MEM_ready;
  logic [31:0] MEM_pc = 0, MEM_inst = 0, MEM_ALUout = 0, MEM_CSR_out = 0;
  logic [4:0]  MEM_rd = 0;
  logic [1:0]  MEM_csr_rd = 0;
  logic        MEM_write_gpr = 0, MEM_write_csr = 0, MEM_mem_to_reg = 0;
  logic        MEM_system_halt = 0, MEM_op_valid = 0, MEM_ALU_valid = 0;
  logic [2:0]  MEM_load_type = 0;
  logic [1:0]  MEM_addr_low = 0;
  logic        dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;
  logic        WB_i_commit;
  logic [31:0] WB_i_pc, WB_i_inst, WB_i_ALU_ALUout, WB_i_ALU_CSR_out, WB_i_rdata;
  logic [4:0]  WB_i_rd;
  logic [1:0]  WB_i_csr_rd;
  logic        WB_i_write_gpr, WB_i_write_csr, WB_i_mem_to_reg;
  logic        WB_i_system_halt, WB_i_op_valid, WB_i_ALU_valid;
`ifdef MEMWB_PERF_CNT_EN
  logic [63:0] perf_retired;
  logic [31:0] perf_load_wait;
`endif

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .MEM_valid(MEM_valid), .MEM_ready(MEM_ready),
    .MEM_pc(MEM_pc), .MEM_inst(MEM_inst),
    .MEM_ALUout(MEM_ALUout), .MEM_CSR_out(MEM_CSR_out),
    .MEM_rd(MEM_rd), .MEM_csr_rd(MEM_csr_rd),
    .MEM_write_gpr(MEM_write_gpr), .MEM_write_csr(MEM_write_csr),
    .MEM_mem_to_reg(MEM_mem_to_reg), .MEM_system_halt(MEM_system_halt),
    .MEM_op_valid(MEM_op_valid), .MEM_ALU_valid(MEM_ALU_valid),
    .MEM_load_type(MEM_load_type), .MEM_addr_low(MEM_addr_low),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .WB_i_commit(WB_i_commit), .WB_i_pc(WB_i_pc), .WB_i_inst(WB_i_inst),
    .WB_i_ALU_ALUout(WB_i_ALU_ALUout), .WB_i_ALU_CSR_out(WB_i_ALU_CSR_out),
    .WB_i_rdata(WB_i_rdata), .WB_i_rd(WB_i_rd), .WB_i_csr_rd(WB_i_csr_rd),
    .WB_i_write_gpr(WB_i_write_gpr), .WB_i_write_csr(WB_i_write_csr),
    .WB_i_mem_to_reg(WB_i_mem_to_reg), .WB_i_system_halt(WB_i_system_halt),
    .WB_i_op_valid(WB_i_op_valid), .WB_i_ALU_valid(WB_i_ALU_valid)
`ifdef MEMWB_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_load_wait(perf_load_wait)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc, inst, alu, csr;
    logic [4:0]  rd;
    logic [1:0]  csr_rd;
    logic        wg, wc, m2r, halt, opv, aluv;
    logic [2:0]  ty;
    logic [1:0]  al;
  } ins_t;

  ins_t        e_b;        // bundle the outputs must currently show
  ins_t        m_pend;     // load waiting for its data
  logic [31:0] e_rdata;
  logic        e_commit;
  bit          m_pending, m_halted;
  longint      m_retired;
  logic [31:0] exp_q[$];   // PCs accepted and not yet retired

  int total = 0;
  int bad   = 0;

  // Reference load result from shift-and-mask arithmetic.
  function automatic logic [31:0] ref_align(logic [2:0] ty, logic [1:0] al, logic [31:0] w);
    logic [31:0] s;
    case (ty)
      3'b000, 3'b100: begin
        s = (w >> (8 * al)) & 32'hFF;
        if (ty == 3'b000 && s >= 32'h80) s = s | 32'hFFFF_FF00;
        return s;
      end
      3'b001, 3'b101: begin
        s = (w >> ((al >= 2) ? 16 : 0)) & 32'hFFFF;
        if (ty == 3'b001 && s >= 32'h8000) s = s | 32'hFFFF_0000;
        return s;
      end
      default: return w;
    endcase
  endfunction

  function automatic ins_t cur_ins();
    ins_t t;
    t.pc = MEM_pc; t.inst = MEM_inst; t.alu = MEM_ALUout; t.csr = MEM_CSR_out;
    t.rd = MEM_rd; t.csr_rd = MEM_csr_rd; t.wg = MEM_write_gpr; t.wc = MEM_write_csr;
    t.m2r = MEM_mem_to_reg; t.halt = MEM_system_halt; t.opv = MEM_op_valid;
    t.aluv = MEM_ALU_valid; t.ty = MEM_load_type; t.al = MEM_addr_low;
    return t;
  endfunction

  task automatic model_reset();
    e_b = '{default: '0};
    m_pend = '{default: '0};
    e_rdata = 0; e_commit = 0;
    m_pending = 0; m_halted = 0; m_retired = 0;
    exp_q.delete();
  endtask

  // Predict the effect of the coming clock edge from the current inputs.
  task automatic model_step();
    e_commit = 0;
    if (m_pending) begin
      if (dmem_rvalid) begin
        e_rdata   = ref_align(m_pend.ty, m_pend.al, dmem_rdata);
        e_commit  = 1;
        m_pending = 0;
        if (m_pend.halt) m_halted = 1;
      end
    end else if (!m_halted && MEM_valid) begin
      e_b = cur_ins();
      exp_q.push_back(MEM_pc);
      if (MEM_mem_to_reg) begin
        m_pending = 1;
        m_pend    = e_b;
      end else begin
        e_commit = 1;
        if (MEM_system_halt) m_halted = 1;
      end
    end
    if (e_commit) m_retired++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [31:0] p;
    chk("ready",  MEM_ready,   !m_pending && !m_halted);
    chk("commit", WB_i_commit, e_commit);
    if (e_commit) begin
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        p = exp_q.pop_front();
        chk("sb_pc", WB_i_pc, p);
      end
    end
    chk("pc",     WB_i_pc,          e_b.pc);
    chk("inst",   WB_i_inst,        e_b.inst);
    chk("alu",    WB_i_ALU_ALUout,  e_b.alu);
    chk("csr",    WB_i_ALU_CSR_out, e_b.csr);
    chk("rdata",  WB_i_rdata,       e_rdata);
    chk("rd",     WB_i_rd,          e_b.rd);
    chk("csr_rd", WB_i_csr_rd,      e_b.csr_rd);
    chk("wgpr",   WB_i_write_gpr,   e_commit && e_b.wg && (e_b.rd != 0));
    chk("wcsr",   WB_i_write_csr,   e_commit && e_b.wc);
    chk("m2r",    WB_i_mem_to_reg,  e_b.m2r);
    chk("halt",   WB_i_system_halt, e_b.halt);
    chk("opv",    WB_i_op_valid,    e_b.opv);
    chk("aluv",   WB_i_ALU_valid,   e_b.aluv);
`ifdef MEMWB_PERF_CNT_EN
    chk("perf_ret", perf_retired, m_retired);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set after a falling edge; this applies them across one
  // rising edge and checks the outputs on the next falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_op(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                        input logic wg, input logic m2r, input logic [2:0] ty,
                        input logic [1:0] al, input logic halt);
    MEM_valid = 1; MEM_pc = pc; MEM_inst = pc ^ 32'h0000_0013; MEM_ALUout = alu;
    MEM_CSR_out = alu + 1; MEM_rd = rd; MEM_csr_rd = 2'd1; MEM_write_gpr = wg;
    MEM_write_csr = 0; MEM_mem_to_reg = m2r; MEM_system_halt = halt;
    MEM_op_valid = 1; MEM_ALU_valid = !m2r; MEM_load_type = ty; MEM_addr_low = al;
  endtask

  task automatic randomize_inputs(input bit allow_halt);
    MEM_valid = $urandom_range(0, 1);
    MEM_pc = $urandom; MEM_inst = $urandom; MEM_ALUout = $urandom; MEM_CSR_out = $urandom;
    MEM_rd = 5'($urandom_range(0, 31)); MEM_csr_rd = 2'($urandom_range(0, 3));
    MEM_write_gpr = $urandom_range(0, 1); MEM_write_csr = $urandom_range(0, 1);
    MEM_mem_to_reg = $urandom_range(0, 1);
    MEM_system_halt = allow_halt ? 1'($urandom_range(0, 1)) : 1'b0;
    MEM_op_valid = $urandom_range(0, 1); MEM_ALU_valid = $urandom_range(0, 1);
    MEM_load_type = 3'($urandom_range(0, 7)); MEM_addr_low = 2'($urandom_range(0, 3));
    dmem_rvalid = ($urandom_range(0, 2) == 0);
    dmem_rdata = $urandom;
  endtask

  // Issue a load, supply data after 'delay' idle response cycles, and
  // return how many sampled cycles showed MEM_ready low.
  task automatic do_load(input logic [2:0] ty, input logic [1:0] al, input logic [31:0] data,
                         input int delay, output int low_cycles);
    low_cycles = 0;
    set_op(32'h0000_1000 + 32'(ty), 5'd7, 32'hA5A5_0000, 1, 1, ty, al, 0);
    tick();
    if (!MEM_ready) low_cycles++;
    MEM_valid = 1;            // keep offering a new instruction; it must wait
    MEM_mem_to_reg = 0;
    dmem_rvalid = 0;
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("load_no_commit", WB_i_commit, 0);
      if (!MEM_ready) low_cycles++;
    end
    MEM_valid = 0;
    dmem_rvalid = 1; dmem_rdata = data;
    tick();
    dmem_rvalid = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int low;
    model_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready",  MEM_ready, 0);
    chk("rst_commit", WB_i_commit, 0);
    chk("rst_pc",     WB_i_pc, 0);
    chk("rst_rdata",  WB_i_rdata, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", MEM_ready, 1);

    // Plain ALU op into x5.
    set_op(32'h0000_0100, 5'd5, 32'h0000_1234, 1, 0, 3'b010, 2'd0, 0);
    tick();
    chk("alu_commit_lit", WB_i_commit, 1);
    chk("alu_wgpr_lit",   WB_i_write_gpr, 1);
    chk("alu_rd_lit",     WB_i_rd, 5);
    chk("alu_out_lit",    WB_i_ALU_ALUout, 32'h0000_1234);
    MEM_valid = 0;
    tick();
    chk("alu_one_pulse", WB_i_commit, 0);

    // Load lane/extension cases, data delivered immediately.
    do_load(3'b000, 2'd3, 32'h80FF_FF00, 0, low);
    chk("lb_lit",  WB_i_rdata, 32'hFFFF_FF80);
    chk("lb_commit", WB_i_commit, 1);
    do_load(3'b100, 2'd3, 32'h80FF_FF00, 0, low);
    chk("lbu_lit", WB_i_rdata, 32'h0000_0080);
    do_load(3'b001, 2'd2, 32'h8001_0000, 0, low);
    chk("lh_lit",  WB_i_rdata, 32'hFFFF_8001);
    do_load(3'b101, 2'd2, 32'h8001_0000, 0, low);
    chk("lhu_lit", WB_i_rdata, 32'h0000_8001);
    do_load(3'b010, 2'd2, 32'h8001_0000, 0, low);
    chk("lw_lit",  WB_i_rdata, 32'h8001_0000);
    chk("min_latency_low", low, 1);

    // Slow memory: four response-less cycles.
    do_load(3'b010, 2'd0, 32'hDEAD_BEEF, 4, low);
    chk("slow_ready_low_cycles", low, 5);
    chk("slow_commit", WB_i_commit, 1);

    // Stray response while idle must be ignored.
    MEM_valid = 0; dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    tick();
    chk("stray_rvalid", WB_i_commit, 0);
    dmem_rvalid = 0;

    // Write to x0 never enables the GPR write.
    set_op(32'h0000_0200, 5'd0, 32'h55, 1, 0, 3'b010, 2'd0, 0);
    tick();
    chk("x0_commit_lit", WB_i_commit, 1);
    chk("x0_wgpr_lit",   WB_i_write_gpr, 0);

    // Back-to-back ALU ops: one commit per cycle.
    for (int i = 0; i < 4; i++) begin
      set_op(32'h0000_0300 + 32'(4 * i), 5'(i + 1), 32'(i), 1, 0, 3'b010, 2'd0, 0);
      tick();
      chk("b2b_commit", WB_i_commit, 1);
    end
    MEM_valid = 0;

    // Random traffic without halts.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(0);
      tick();
    end
    MEM_valid = 0;
    for (int i = 0; i < 4 && m_pending; i++) begin
      dmem_rvalid = 1;
      tick();
    end
    dmem_rvalid = 0;
    tick();
    chk("drain_empty", exp_q.size(), 0);

    // Halt: commits, then nothing more is accepted.
    set_op(32'h0000_0400, 5'd3, 32'h77, 1, 0, 3'b010, 2'd0, 1);
    tick();
    chk("halt_commit_lit", WB_i_commit, 1);
    chk("halt_flag_lit",   WB_i_system_halt, 1);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      randomize_inputs(0);
      MEM_valid = 1;
      tick();
      if (!MEM_ready && !WB_i_commit) low++;
    end
    chk("halted_20_lit", low, 20);

    // Reset with a load outstanding drops it.
    rst = 1;
    @(negedge clk);
    model_reset();
    rst = 0;
    MEM_valid = 0; dmem_rvalid = 0;
    #1;
    chk("halt_reset_ready", MEM_ready, 1);
    set_op(32'h0000_0500, 5'd9, 32'h99, 1, 1, 3'b000, 2'd1, 0);
    tick();
    MEM_valid = 0;
    tick();
    #2;
    rst = 1;
    #1;
    chk("midload_rst_ready",  MEM_ready, 0);
    chk("midload_rst_commit", WB_i_commit, 0);
    chk("midload_rst_pc",     WB_i_pc, 0);
    chk("midload_rst_m2r",    WB_i_mem_to_reg, 0);
    dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 0;
    model_reset();
    tick();
    chk("midload_no_commit", WB_i_commit, 0);
    dmem_rvalid = 0;
    tick();
    chk("midload_rdata_zero", WB_i_rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
